regfile_wb_unit: RTL and testbench

Write-side front end of the general-purpose register file. It arbitrates completed results from EXU and LSU onto the register file's single write port (wen/waddr/wdata) and owns the scoreboard of registers with writes still in flight. Sits between the execute/memory stages and the register file. IDU queries it to stall on RAW/WAW hazards.

---
 rtl/regfile_wb_unit_pkg.sv | 13 +
 rtl/regfile_scoreboard.sv | 70 +++++++
 rtl/regfile_wb_unit.sv | 105 ++++++++++
 tb/tb_regfile_wb_unit.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_unit_pkg.sv
// Shared types and constants for the register-file writeback unit.
package regfile_wb_unit_pkg;

  typedef enum logic {
    SRC_LSU = 1'b0,
    SRC_EXU = 1'b1
  } src_e;

  localparam int unsigned DEF_ADDR_WIDTH = 5;
  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned REG_ZERO       = 0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: tracks registers with writes in flight, answers hazard queries,
// keeps a registered popcount and a sticky error for unexpected writebacks.
module regfile_scoreboard
  import regfile_wb_unit_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  set_valid,
  input  logic [ADDR_WIDTH-1:0] set_addr,
  input  logic                  clr_valid,
  input  logic [ADDR_WIDTH-1:0] clr_addr,
  input  logic [ADDR_WIDTH-1:0] issue_addr,
  input  logic [ADDR_WIDTH-1:0] q1_addr,
  input  logic [ADDR_WIDTH-1:0] q2_addr,
  output logic                  issue_busy,
  output logic                  q1_busy,
  output logic                  q2_busy,
  output logic [ADDR_WIDTH:0]   busy_count,
  output logic                  wb_err
);

  localparam int unsigned NumRegs = 2 ** ADDR_WIDTH;

  logic [NumRegs-1:0] busy_q, busy_d;
  logic [ADDR_WIDTH:0] count_q, count_d;
  logic                wb_err_q, wb_err_d;

  assign issue_busy = busy_q[issue_addr];
  assign q1_busy    = busy_q[q1_addr];
  assign q2_busy    = busy_q[q2_addr];
  assign busy_count = count_q;
  assign wb_err     = wb_err_q;

  always_comb begin
    busy_d   = busy_q;
    wb_err_d = wb_err_q;
    if (clr_valid) begin
      busy_d[clr_addr] = 1'b0;
      if (clr_addr != ADDR_WIDTH'(REG_ZERO) && !busy_q[clr_addr]) begin
        wb_err_d = 1'b1;
      end
    end
    if (set_valid && set_addr != ADDR_WIDTH'(REG_ZERO)) begin
      busy_d[set_addr] = 1'b1;
    end
    busy_d[REG_ZERO] = 1'b0;
  end

  always_comb begin
    count_d = '0;
    for (int unsigned i = 0; i < NumRegs; i++) begin
      count_d = count_d + (ADDR_WIDTH + 1)'(busy_d[i]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q   <= '0;
      count_q  <= '0;
      wb_err_q <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      count_q  <= count_d;
      wb_err_q <= wb_err_d;
    end
  end

endmodule

// File: rtl/regfile_wb_unit.sv
// Writeback front end: round-robin arbitration of EXU/LSU results onto the single
// register-file write port, plus the in-flight write scoreboard.
module regfile_wb_unit
  import regfile_wb_unit_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  issue_valid,
  input  logic [ADDR_WIDTH-1:0] issue_rd,
  output logic                  issue_ready,
  input  logic                  exu_valid,
  input  logic [ADDR_WIDTH-1:0] exu_rd,
  input  logic [DATA_WIDTH-1:0] exu_data,
  output logic                  exu_ready,
  input  logic                  lsu_valid,
  input  logic [ADDR_WIDTH-1:0] lsu_rd,
  input  logic [DATA_WIDTH-1:0] lsu_data,
  output logic                  lsu_ready,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic [ADDR_WIDTH:0]   busy_count,
  output logic                  wb_err
);

  src_e                  rr_q, rr_d;
  logic                  rf_wen_q, rf_wen_d;
  logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
  logic                  grant_exu, grant_lsu, issue_busy;

  always_comb begin
    grant_exu = exu_valid && (!lsu_valid || rr_q == SRC_EXU);
    grant_lsu = lsu_valid && !grant_exu;
    rr_d      = rr_q;
    // Pointer only moves on contended grants.
    if (exu_valid && lsu_valid) begin
      rr_d = grant_exu ? SRC_LSU : SRC_EXU;
    end
  end

  assign exu_ready = grant_exu;
  assign lsu_ready = grant_lsu;

  always_comb begin
    rf_wen_d   = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (grant_exu) begin
      rf_wen_d   = exu_rd != ADDR_WIDTH'(REG_ZERO);
      rf_waddr_d = exu_rd;
      rf_wdata_d = exu_data;
    end else if (grant_lsu) begin
      rf_wen_d   = lsu_rd != ADDR_WIDTH'(REG_ZERO);
      rf_waddr_d = lsu_rd;
      rf_wdata_d = lsu_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_q       <= SRC_LSU;
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      rr_q       <= rr_d;
      rf_wen_q   <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign rf_wen      = rf_wen_q;
  assign rf_waddr    = rf_waddr_q;
  assign rf_wdata    = rf_wdata_q;
  assign issue_ready = !issue_busy;

  regfile_scoreboard #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_scoreboard (
    .clock     (clock),
    .reset     (reset),
    .set_valid (issue_valid && issue_ready),
    .set_addr  (issue_rd),
    .clr_valid (rf_wen_q),
    .clr_addr  (rf_waddr_q),
    .issue_addr(issue_rd),
    .q1_addr   (rs1_addr),
    .q2_addr   (rs2_addr),
    .issue_busy(issue_busy),
    .q1_busy   (rs1_busy),
    .q2_busy   (rs2_busy),
    .busy_count(busy_count),
    .wb_err    (wb_err)
  );

endmodule

// File: tb/tb_regfile_wb_unit.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural model.
module tb_regfile_wb_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_ready;
  logic        exu_valid;
  logic [4:0]  exu_rd;
  logic [31:0] exu_data;
  logic        exu_ready;
  logic        lsu_valid;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        lsu_ready;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic        rs1_busy;
  logic        rs2_busy;
  logic [5:0]  busy_count;
  logic        wb_err;

  always #5 clock = ~clock;

  regfile_wb_unit dut (
    .clock      (clock),
    .reset      (reset),
    .issue_valid(issue_valid),
    .issue_rd   (issue_rd),
    .issue_ready(issue_ready),
    .exu_valid  (exu_valid),
    .exu_rd     (exu_rd),
    .exu_data   (exu_data),
    .exu_ready  (exu_ready),
    .lsu_valid  (lsu_valid),
    .lsu_rd     (lsu_rd),
    .lsu_data   (lsu_data),
    .lsu_ready  (lsu_ready),
    .rf_wen     (rf_wen),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .rs1_busy   (rs1_busy),
    .rs2_busy   (rs2_busy),
    .busy_count (busy_count),
    .wb_err     (wb_err)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  bit          m_busy[32];
  bit          m_exu_turn;   // 1: EXU wins next contention
  bit          m_wen;
  int unsigned m_waddr;
  int unsigned m_wdata;
  bit          m_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_gexu();
    return exu_valid && (!lsu_valid || m_exu_turn);
  endfunction

  function automatic int unsigned m_count();
    int unsigned n = 0;
    for (int i = 0; i < 32; i++) n += m_busy[i];
    return n;
  endfunction

  task automatic compare_all();
    bit ge, gl;
    ge = m_gexu();
    gl = lsu_valid && !ge;
    chk("issue_ready", issue_ready, !m_busy[issue_rd]);
    chk("exu_ready", exu_ready, ge);
    chk("lsu_ready", lsu_ready, gl);
    chk("rs1_busy", rs1_busy, m_busy[rs1_addr]);
    chk("rs2_busy", rs2_busy, m_busy[rs2_addr]);
    chk("rf_wen", rf_wen, m_wen);
    if (m_wen) begin
      chk("rf_waddr", rf_waddr, m_waddr);
      chk("rf_wdata", rf_wdata, m_wdata);
    end
    chk("busy_count", busy_count, m_count());
    chk("wb_err", wb_err, m_err);
  endtask

  task automatic model_step();
    bit ge, gl, iss_ok;
    if (reset) begin
      foreach (m_busy[i]) m_busy[i] = 0;
      m_exu_turn = 0;
      m_wen = 0;
      m_waddr = 0;
      m_wdata = 0;
      m_err = 0;
      return;
    end
    ge = m_gexu();
    gl = lsu_valid && !ge;
    iss_ok = issue_valid && !m_busy[issue_rd] && issue_rd != 0;
    if (m_wen) begin
      if (m_waddr != 0 && !m_busy[m_waddr]) m_err = 1;
      m_busy[m_waddr] = 0;
    end
    if (iss_ok) m_busy[issue_rd] = 1;
    if (exu_valid && lsu_valid) m_exu_turn = gl;
    m_wen = 0;
    if (ge) begin
      m_wen = exu_rd != 0; m_waddr = exu_rd; m_wdata = exu_data;
    end else if (gl) begin
      m_wen = lsu_rd != 0; m_waddr = lsu_rd; m_wdata = lsu_data;
    end
  endtask

  task automatic settle();
    @(negedge clock);
    compare_all();
  endtask

  task automatic advance();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    issue_valid = 0; exu_valid = 0; lsu_valid = 0;
  endtask

  task automatic issue(input logic [4:0] rd);
    idle_inputs();
    issue_valid = 1; issue_rd = rd;
    settle(); advance();
    issue_valid = 0;
  endtask

  initial begin
    reset = 1; idle_inputs();
    issue_rd = 0; exu_rd = 0; lsu_rd = 0; exu_data = 0; lsu_data = 0;
    rs1_addr = 0; rs2_addr = 0;
    advance(); advance();
    reset = 0;

    // Reset state
    settle();
    chk("rst_rf_wen", rf_wen, 1'b0);
    chk("rst_rf_waddr", rf_waddr, 5'd0);
    chk("rst_rf_wdata", rf_wdata, 32'd0);
    chk("rst_busy_count", busy_count, 6'd0);
    chk("rst_wb_err", wb_err, 1'b0);
    advance();

    // Issue rd=5, then again while busy
    issue_valid = 1; issue_rd = 5; rs1_addr = 5;
    settle();
    chk("iss5_ready", issue_ready, 1'b1);
    chk("iss5_rs1_pre", rs1_busy, 1'b0);
    advance();
    settle();
    chk("iss5_again_ready", issue_ready, 1'b0);
    chk("iss5_rs1_busy", rs1_busy, 1'b1);
    chk("iss5_count", busy_count, 6'd1);
    advance();

    // EXU writeback of rd=5
    idle_inputs();
    exu_valid = 1; exu_rd = 5; exu_data = 32'hDEADBEEF;
    settle();
    chk("exu5_ready", exu_ready, 1'b1);
    advance();
    exu_valid = 0;
    settle();
    chk("wb5_wen", rf_wen, 1'b1);
    chk("wb5_waddr", rf_waddr, 5'd5);
    chk("wb5_wdata", rf_wdata, 32'hDEADBEEF);
    chk("wb5_still_busy", rs1_busy, 1'b1);
    advance();
    settle();
    chk("wb5_cleared", rs1_busy, 1'b0);
    chk("wb5_count", busy_count, 6'd0);
    advance();

    // Contention: EXU rd=3, LSU rd=4
    issue(3); issue(4);
    exu_valid = 1; exu_rd = 3; exu_data = 32'h33;
    lsu_valid = 1; lsu_rd = 4; lsu_data = 32'h44;
    settle();
    chk("pair1_lsu_first", lsu_ready, 1'b1);
    chk("pair1_exu_wait", exu_ready, 1'b0);
    advance();
    lsu_valid = 0;
    settle();
    chk("pair1_exu_next", exu_ready, 1'b1);
    chk("pair1_wen_a", rf_wen, 1'b1);
    chk("pair1_waddr_a", rf_waddr, 5'd4);
    advance();
    exu_valid = 0;
    settle();
    chk("pair1_wen_b", rf_wen, 1'b1);
    chk("pair1_waddr_b", rf_waddr, 5'd3);
    advance();

    // Next pair: pointer now favours EXU
    issue(10); issue(11);
    exu_valid = 1; exu_rd = 10; exu_data = 32'hA;
    lsu_valid = 1; lsu_rd = 11; lsu_data = 32'hB;
    settle();
    chk("pair2_exu_first", exu_ready, 1'b1);
    advance();
    exu_valid = 0;
    settle();
    chk("pair2_lsu_next", lsu_ready, 1'b1);
    advance();
    idle_inputs();
    settle(); advance();

    // rd=0 result
    exu_valid = 1; exu_rd = 0; exu_data = 32'h1234;
    settle();
    chk("rd0_ready", exu_ready, 1'b1);
    advance();
    exu_valid = 0;
    settle();
    chk("rd0_wen", rf_wen, 1'b0);
    chk("rd0_count", busy_count, 6'd0);
    chk("rd0_err", wb_err, 1'b0);
    advance();

    // Writeback to never-issued rd=7
    lsu_valid = 1; lsu_rd = 7; lsu_data = 32'h77;
    settle(); advance();
    lsu_valid = 0;
    settle();
    chk("rd7_wen", rf_wen, 1'b1);
    chk("rd7_waddr", rf_waddr, 5'd7);
    advance();
    settle();
    chk("rd7_err", wb_err, 1'b1);
    advance();
    issue(12);
    settle();
    chk("rd7_err_sticky", wb_err, 1'b1);
    advance();

    // Reset during the rf_wen cycle
    issue(9);
    lsu_valid = 1; lsu_rd = 9; lsu_data = 32'h99;
    settle(); advance();
    lsu_valid = 0;
    settle();
    chk("rst9_wen_pre", rf_wen, 1'b1);
    reset = 1;
    advance();
    reset = 0; issue_rd = 9;
    settle();
    chk("rst9_wen", rf_wen, 1'b0);
    chk("rst9_count", busy_count, 6'd0);
    chk("rst9_ready", issue_ready, 1'b1);
    chk("rst9_err", wb_err, 1'b0);
    advance();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      reset       = ($urandom_range(299) == 0);
      issue_valid = $urandom_range(1);
      issue_rd    = 5'($urandom);
      exu_valid   = ($urandom_range(2) == 0);
      lsu_valid   = ($urandom_range(2) == 0);
      exu_rd      = 5'($urandom);
      lsu_rd      = 5'($urandom);
      exu_data    = $urandom;
      lsu_data    = $urandom;
      rs1_addr    = 5'($urandom);
      rs2_addr    = 5'($urandom);
      // Mostly complete registers that are actually pending
      if ($urandom_range(7) != 0) begin
        for (int k = 0; k < 8; k++) if (!m_busy[exu_rd]) exu_rd = 5'($urandom);
        for (int k = 0; k < 8; k++) if (!m_busy[lsu_rd]) lsu_rd = 5'($urandom);
      end
      if (reset) begin
        @(negedge clock);
      end else begin
        settle();
      end
      advance();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
